// File: rtl/mem_stage_pkg.sv
// Shared LC-3b pipeline types for the MEM stage: word type, control word,
// EX/MEM and MEM/WB bundles, and the MEM-stage FSM encoding.
package mem_stage_pkg;

  typedef logic [15:0] lc3b_word;

  typedef struct packed {
    logic       load_regfile;
    logic [2:0] dest;
    logic       mem_read;
    logic       mem_write;
    logic       indirect;
    logic       byte_op;
  } lc3b_control_word;

  typedef struct packed {
    logic             valid;
    lc3b_control_word control_signals;
    lc3b_word         alu_out;
    lc3b_word         src_data;
    lc3b_word         pc_out;
    logic             intr;
  } EX_MEM;

  typedef struct packed {
    logic             valid;
    lc3b_control_word control_signals;
    lc3b_word         alu_out;
    lc3b_word         mem_data;
    lc3b_word         pc_out;
    logic             intr;
  } MEM_WB;

  typedef enum logic [1:0] {
    IDLE,
    FIRST,
    SECOND
  } mem_stage_state;

  function automatic lc3b_word sext_byte(input logic [7:0] b);
    return {{8{b[7]}}, b};
  endfunction

endpackage

// File: rtl/mem_stage_align.sv
// Combinational byte-lane steering for data memory: address alignment,
// byte enables, store-data replication and load-data extraction.
module mem_stage_align
  import mem_stage_pkg::*;
(
  input  lc3b_word   address,
  input  logic       byte_op,
  input  lc3b_word   src_data,
  input  lc3b_word   dmem_rdata,
  output lc3b_word   aligned_address,
  output logic [1:0] byte_enable,
  output lc3b_word   wdata,
  output lc3b_word   rdata
);

  always_comb begin
    aligned_address = {address[15:1], 1'b0};
    byte_enable     = 2'b11;
    wdata           = src_data;
    rdata           = dmem_rdata;
    if (byte_op) begin
      aligned_address = address;
      byte_enable     = address[0] ? 2'b10 : 2'b01;
      wdata           = {src_data[7:0], src_data[7:0]};
      rdata           = sext_byte(address[0] ? dmem_rdata[15:8] : dmem_rdata[7:0]);
    end
  end

endmodule

// File: rtl/mem_stage.sv
// LC-3b MEM stage: runs the data-memory handshake (word, byte, indirect)
// and registers the MEM/WB bundle, stalling upstream while busy.
module mem_stage
  import mem_stage_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  EX_MEM      ex_mem,
  input  logic       dmem_resp,
  input  lc3b_word   dmem_rdata,
  output logic       dmem_read,
  output logic       dmem_write,
  output lc3b_word   dmem_address,
  output lc3b_word   dmem_wdata,
  output logic [1:0] dmem_byte_enable,
  output logic       stall,
  output MEM_WB      mem_wb
);

  mem_stage_state   state, state_next;
  lc3b_word         ind_addr;
  lc3b_control_word cs;
  logic             mem_op;
  logic             final_access;
  logic             access_byte;
  lc3b_word         raw_addr;
  lc3b_word         al_rdata;

  assign cs     = ex_mem.control_signals;
  assign mem_op = ex_mem.valid & (cs.mem_read | cs.mem_write);

  always_comb begin
    state_next   = state;
    dmem_read    = 1'b0;
    dmem_write   = 1'b0;
    raw_addr     = ex_mem.alu_out;
    access_byte  = 1'b0;
    final_access = 1'b0;
    unique case (state)
      IDLE: begin
        if (mem_op) state_next = FIRST;
      end
      FIRST: begin
        // The pointer fetch of an indirect op is always a word read.
        access_byte  = cs.byte_op & ~cs.indirect;
        final_access = ~cs.indirect;
        dmem_read    = cs.mem_read | cs.indirect;
        dmem_write   = cs.mem_write & ~cs.indirect;
        if (dmem_resp) state_next = cs.indirect ? SECOND : IDLE;
      end
      SECOND: begin
        raw_addr     = ind_addr;
        final_access = 1'b1;
        dmem_read    = cs.mem_read;
        dmem_write   = cs.mem_write;
        if (dmem_resp) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Gated by rst_n so stall is low while reset is held, even with a load pending.
  assign stall = rst_n & (((state == IDLE) & mem_op) |
                          ((state != IDLE) & ~(dmem_resp & final_access)));

  mem_stage_align u_align (
    .address         (raw_addr),
    .byte_op         (access_byte),
    .src_data        (ex_mem.src_data),
    .dmem_rdata      (dmem_rdata),
    .aligned_address (dmem_address),
    .byte_enable     (dmem_byte_enable),
    .wdata           (dmem_wdata),
    .rdata           (al_rdata)
  );

  // With stall low, a non-IDLE state can only mean the final response is here.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      ind_addr <= '0;
      mem_wb   <= '0;
    end else begin
      state <= state_next;
      if (state == FIRST && dmem_resp && cs.indirect) ind_addr <= dmem_rdata;
      if (!stall) begin
        mem_wb <= '{valid:           ex_mem.valid,
                    control_signals: cs,
                    alu_out:         ex_mem.alu_out,
                    mem_data:        (state != IDLE && cs.mem_read) ? al_rdata : '0,
                    pc_out:          ex_mem.pc_out,
                    intr:            ex_mem.intr};
      end
    end
  end

endmodule

// File: tb/tb_mem_stage.sv
// Directed + randomized bench for mem_stage against a transaction-level
// model of the expected memory accesses, stall length and MEM/WB result.
module tb_mem_stage;
  import mem_stage_pkg::*;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  EX_MEM      ex_mem;
  logic       dmem_resp;
  lc3b_word   dmem_rdata;
  logic       dmem_read;
  logic       dmem_write;
  lc3b_word   dmem_address;
  lc3b_word   dmem_wdata;
  logic [1:0] dmem_byte_enable;
  logic       stall;
  MEM_WB      mem_wb;

  int checks = 0;
  int failures = 0;

  lc3b_word mem [lc3b_word];

  typedef struct {
    logic       wr;
    lc3b_word   addr;
    logic [1:0] be;
    lc3b_word   wdata;
  } acc_t;

  mem_stage dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .ex_mem           (ex_mem),
    .dmem_resp        (dmem_resp),
    .dmem_rdata       (dmem_rdata),
    .dmem_read        (dmem_read),
    .dmem_write       (dmem_write),
    .dmem_address     (dmem_address),
    .dmem_wdata       (dmem_wdata),
    .dmem_byte_enable (dmem_byte_enable),
    .stall            (stall),
    .mem_wb           (mem_wb)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic lc3b_word mem_rd(input lc3b_word a);
    lc3b_word k = {a[15:1], 1'b0};
    return mem.exists(k) ? mem[k] : (k ^ 16'hC3A5);
  endfunction

  function automatic void mem_wr(input lc3b_word a, input logic [1:0] be, input lc3b_word d);
    lc3b_word k = {a[15:1], 1'b0};
    lc3b_word w = mem_rd(a);
    if (be[0]) w[7:0] = d[7:0];
    if (be[1]) w[15:8] = d[15:8];
    mem[k] = w;
  endfunction

  function automatic EX_MEM mk(input logic v, input logic rd, input logic wr, input logic ind,
                               input logic bop, input lc3b_word alu, input lc3b_word src);
    EX_MEM e;
    e.valid                        = v;
    e.control_signals.load_regfile = ~wr;
    e.control_signals.dest         = 3'($urandom);
    e.control_signals.mem_read     = rd;
    e.control_signals.mem_write    = wr;
    e.control_signals.indirect     = ind;
    e.control_signals.byte_op      = bop;
    e.alu_out                      = alu;
    e.src_data                     = src;
    e.pc_out                       = 16'($urandom);
    e.intr                         = 1'($urandom);
    return e;
  endfunction

  // Drives one EX/MEM bundle, plays the memory with the given wait counts,
  // and compares every cycle against the access list derived from the op.
  task automatic run_op(input string name, input EX_MEM e, input int w0, input int w1);
    acc_t             q[$];
    acc_t             a;
    int               wt[2];
    lc3b_word         exp_md = '0;
    lc3b_word         ea, ptr, w;
    logic [7:0]       b;
    MEM_WB            exp_wb, prev_wb;
    int               idx = 0, wc = 0, cyc = 0, stalls = 0, exp_stalls = 0;
    logic             done = 1'b0, resp, last, do_wr;
    lc3b_word         wr_a, wr_d;
    logic [1:0]       wr_be;
    lc3b_control_word c = e.control_signals;
    wt[0] = w0;
    wt[1] = w1;

    if (e.valid && (c.mem_read || c.mem_write)) begin
      ea = e.alu_out;
      if (c.indirect) begin
        ptr = mem_rd(ea);
        q.push_back('{wr: 1'b0, addr: ea & 16'hFFFE, be: 2'b11, wdata: 16'h0});
        ea = ptr & 16'hFFFE;
        q.push_back('{wr: c.mem_write, addr: ea, be: 2'b11, wdata: e.src_data});
        if (c.mem_read) exp_md = mem_rd(ea);
      end else if (c.byte_op) begin
        q.push_back('{wr: c.mem_write, addr: ea, be: ea[0] ? 2'b10 : 2'b01,
                      wdata: {e.src_data[7:0], e.src_data[7:0]}});
        w = mem_rd(ea);
        b = ea[0] ? w[15:8] : w[7:0];
        if (c.mem_read) exp_md = {{8{b[7]}}, b};
      end else begin
        q.push_back('{wr: c.mem_write, addr: ea & 16'hFFFE, be: 2'b11, wdata: e.src_data});
        if (c.mem_read) exp_md = mem_rd(ea);
      end
      exp_stalls = q.size();
      for (int i = 0; i < q.size(); i++) exp_stalls += wt[i];
    end
    exp_wb = '{valid: e.valid, control_signals: c, alu_out: e.alu_out,
               mem_data: exp_md, pc_out: e.pc_out, intr: e.intr};

    while (!done) begin
      @(negedge clk);
      if (cyc == 0) begin
        ex_mem  = e;
        prev_wb = mem_wb;
      end
      #1;
      resp  = 1'b0;
      last  = 1'b0;
      do_wr = 1'b0;
      if (cyc == 0 || idx >= q.size()) begin
        chk({name, ":noreq"}, {62'h0, dmem_read, dmem_write}, 64'h0);
      end else begin
        a = q[idx];
        chk({name, ":req"},
            {dmem_read, dmem_write, dmem_address, dmem_byte_enable, dmem_write ? dmem_wdata : 16'h0},
            {~a.wr, a.wr, a.addr, a.be, a.wr ? a.wdata : 16'h0});
        if (wc == wt[idx]) begin
          resp = 1'b1;
          last = (idx == q.size() - 1);
          idx++;
          wc = 0;
        end else begin
          wc++;
        end
      end
      dmem_resp  = resp;
      dmem_rdata = resp ? mem_rd(dmem_address) : 16'($urandom);
      if (resp && dmem_write) begin
        do_wr = 1'b1;
        wr_a  = dmem_address;
        wr_be = dmem_byte_enable;
        wr_d  = dmem_wdata;
      end
      #1;
      chk({name, ":stall"}, {63'h0, stall}, {63'h0, (q.size() != 0) && !last});
      if (stall) stalls++;
      done = (q.size() == 0) || last;
      @(posedge clk);
      if (do_wr) mem_wr(wr_a, wr_be, wr_d);
      #1;
      dmem_resp = 1'b0;
      if (!done) chk({name, ":wb_hold"}, 64'(mem_wb), 64'(prev_wb));
      cyc++;
      if (!done && cyc > 40) begin
        checks++;
        failures++;
        $error("FAIL %s:timeout observed cycles=%0d required completion within 40", name, cyc);
        break;
      end
    end
    if (done) begin
      chk({name, ":mem_wb"}, 64'(mem_wb), 64'(exp_wb));
      chk({name, ":stall_cycles"}, 64'(stalls), 64'(exp_stalls));
    end
  endtask

  initial begin
    EX_MEM e;
    int    k;
    dmem_resp  = 1'b0;
    dmem_rdata = '0;
    ex_mem     = mk(1, 1, 0, 0, 0, 16'h1000, 16'h0);

    #3;
    chk("reset:mem_wb", 64'(mem_wb), 64'h0);
    chk("reset:outs", {61'h0, dmem_read, dmem_write, stall}, 64'h0);
    @(negedge clk);
    ex_mem = mk(0, 0, 0, 0, 0, 16'h0, 16'h0);
    rst_n  = 1'b1;

    mem[16'h1002] = 16'hBEEF;
    mem[16'h2000] = 16'h8A11;
    mem[16'h3000] = 16'h7777;
    mem[16'h4000] = 16'h5000;

    run_op("add", mk(1, 0, 0, 0, 0, 16'h0042, 16'h1111), 0, 0);
    run_op("ldr_wait3", mk(1, 1, 0, 0, 0, 16'h1003, 16'h0), 3, 0);
    run_op("ldb_hi", mk(1, 1, 0, 0, 1, 16'h2001, 16'h0), 0, 0);
    run_op("ldb_lo", mk(1, 1, 0, 0, 1, 16'h2000, 16'h0), 1, 0);
    run_op("stb_hi", mk(1, 0, 1, 0, 1, 16'h3001, 16'h12CD), 0, 0);
    chk("stb_hi:mem", 64'(mem_rd(16'h3000)), 64'h0000_0000_0000_CD77);
    run_op("sti", mk(1, 0, 1, 1, 0, 16'h4000, 16'hA5A5), 0, 0);
    chk("sti:mem", 64'(mem_rd(16'h5000)), 64'h0000_0000_0000_A5A5);
    run_op("bubble", mk(0, 1, 0, 0, 0, 16'h2222, 16'h0), 0, 0);

    // Reset asserted during the second access of an LDI.
    mem[16'h6000] = 16'h7000;
    mem[16'h7000] = 16'h1234;
    @(negedge clk);
    ex_mem = mk(1, 1, 0, 1, 0, 16'h6000, 16'h0);
    @(negedge clk);
    #1;
    chk("rst_ldi:first", {47'h0, dmem_read, dmem_address}, {47'h0, 1'b1, 16'h6000});
    dmem_resp  = 1'b1;
    dmem_rdata = mem_rd(16'h6000);
    @(posedge clk);
    #1;
    dmem_resp = 1'b0;
    @(negedge clk);
    #1;
    chk("rst_ldi:second", {47'h0, dmem_read, dmem_address}, {47'h0, 1'b1, 16'h7000});
    rst_n = 1'b0;
    #1;
    chk("rst_ldi:outs", {60'h0, dmem_read, dmem_write, stall, mem_wb.valid}, 64'h0);
    chk("rst_ldi:mem_wb", 64'(mem_wb), 64'h0);
    ex_mem = mk(0, 0, 0, 0, 0, 16'h0, 16'h0);
    #1;
    rst_n = 1'b1;
    run_op("post_rst_ldi", mk(1, 1, 0, 1, 0, 16'h6000, 16'h0), 0, 1);

    for (int n = 0; n < 60; n++) begin
      k = int'($urandom_range(0, 7));
      case (k)
        0:       e = mk(1, 0, 0, 0, 0, 16'($urandom), 16'($urandom));
        1:       e = mk(1, 1, 0, 0, 0, 16'($urandom), 16'($urandom));
        2:       e = mk(1, 0, 1, 0, 0, 16'($urandom), 16'($urandom));
        3:       e = mk(1, 1, 0, 0, 1, 16'($urandom), 16'($urandom));
        4:       e = mk(1, 0, 1, 0, 1, 16'($urandom), 16'($urandom));
        5:       e = mk(1, 1, 0, 1, 0, 16'($urandom), 16'($urandom));
        6:       e = mk(1, 0, 1, 1, 0, 16'($urandom), 16'($urandom));
        default: e = mk(0, 1'($urandom), 1'($urandom), 0, 0, 16'($urandom), 16'($urandom));
      endcase
      run_op($sformatf("rand%0d_k%0d", n, k), e,
             int'($urandom_range(0, 3)), int'($urandom_range(0, 3)));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mem_stage.md
Name: mem_stage

Overview:
- Pipeline MEM stage of the LC-3b core. Consumes the EX/MEM bundle and runs the data-memory handshake, including LDB/STB byte lanes and LDI/STI double access.
- Produces the registered MEM/WB bundle that the writeback stage reads: control_signals, alu_out, mem_data, pc_out, intr.
- Stalls upstream stages while a memory access is outstanding.

Parameters:
- none. Widths come from lc3b_types (lc3b_word = 16 bits).

Ports:
- clk  in  1  pipeline clock.
- rst_n  in  1  reset, asynchronous, active-low.
- ex_mem  in  EX_MEM  EX/MEM bundle: valid, control_signals, alu_out (address/result), src_data (store data), pc_out, intr.
- dmem_resp  in  1  data memory response: read data valid or write complete, single-cycle pulse.
- dmem_rdata  in  16  data memory read data.
- dmem_read  out  1  read request.
- dmem_write  out  1  write request.
- dmem_address  out  16  access address.
- dmem_wdata  out  16  write data.
- dmem_byte_enable  out  2  byte lanes; [1] = high byte.
- stall  out  1  freeze the PC, IF/ID, ID/EX and EX/MEM registers.
- mem_wb  out  MEM_WB  registered MEM/WB bundle.

Behaviour:
- Reset, asynchronous on rst_n low:
  - state = IDLE.
  - mem_wb = all zeros (valid = 0, the NOP encoding).
  - dmem_read, dmem_write, stall = 0.
  - indirect address register = 0.
- Reset mid-access abandons the access immediately. The memory side must tolerate a request dropping without a resp.
- mem_op = ex_mem.valid & (control_signals.mem_read | control_signals.mem_write).
- States: IDLE, FIRST, SECOND.
- IDLE:
  - If mem_op: go to FIRST, stall = 1.
  - Otherwise stall = 0, and mem_wb loads from ex_mem at the clock edge with mem_data = 0. Latency is 1 cycle.
- FIRST:
  - Assert dmem_read or dmem_write per the control signals. An indirect op always reads in FIRST.
  - Address = alu_out.
  - On dmem_resp with indirect: capture dmem_rdata into ind_addr, go to SECOND.
  - On dmem_resp without indirect: complete the op.
- SECOND:
  - Address = ind_addr.
  - LDI reads; STI writes src_data.
  - On dmem_resp: complete the op.
- Complete:
  - mem_wb loads ex_mem fields plus mem_data, state returns to IDLE, stall drops in the same cycle.
  - mem_wb is never updated while stall is high.
- Requests are held stable (address, data, enables) until dmem_resp. Requests deassert in the cycle after resp.
- stall = (state==IDLE & mem_op) | (state!=IDLE & !(dmem_resp & final_access)).
- Word access:
  - byte_enable = 2'b11.
  - Address bit0 forced to 0.
  - mem_data = dmem_rdata.
- Byte access (control_signals.byte_op):
  - Address passes unmodified.
  - byte_enable = addr[0] ? 2'b10 : 2'b01.
  - wdata = {src_data[7:0], src_data[7:0]}.
  - LDB mem_data = sign-extend of the selected byte.
- Indirection always uses word access for the pointer fetch. Byte ops are never indirect.
- Bubbles (ex_mem.valid = 0) pass through as NOPs in 1 cycle.
- Zero-wait memory (resp in the first FIRST cycle) gives 2 cycles for a load/store and 3 for LDI/STI.

Decomposition:
- lc3b_types additions:
  - EX_MEM struct.
  - control_signals fields mem_read, mem_write, indirect, byte_op.
  - mem_stage_state enum {IDLE, FIRST, SECOND}.
- Sub-module: mem_align, combinational.
  - Inputs: address, byte_op, src_data, dmem_rdata.
  - Outputs: byte_enable, wdata, aligned read data.
  - The FSM and registers stay in mem_stage.

Test Plan:
- ADD, valid=1, no mem op, alu_out=16'h0042 → stall=0; next edge mem_wb.alu_out=16'h0042, mem_data=0; no dmem request.
- LDR addr 16'h1003, memory returns 16'hBEEF after 3 wait cycles → dmem_address=16'h1002, byte_enable=2'b11, stall high for 4 cycles; mem_wb.mem_data=16'hBEEF one edge after resp.
- LDB addr 16'h2001, rdata 16'h8A11 → byte_enable=2'b10, mem_data=16'hFF8A. At addr 16'h2000 → mem_data=16'h0011.
- STB addr 16'h3001, src_data=16'h12CD → dmem_write=1, wdata=16'hCDCD, byte_enable=2'b10; no read issued.
- STI alu_out=16'h4000, mem[4000]=16'h5000, src_data=16'hA5A5 → read at 4000, then write 16'hA5A5 at 5000; zero-wait total stall = 2 cycles; exactly one write.
- rst_n pulsed low during SECOND of an LDI → asynchronously: dmem_read=0, stall=0, mem_wb.valid=0, state=IDLE; the next op issues normally.
